// File: rtl/inst_queue_mw.sv
// Multi-write / multi-read instruction queue between fetch and decode.
// Optional CMOV serialisation is enabled by defining CMOV_SPLIT_EN.
module inst_queue_mw #(
    parameter int DEPTH = 32,
    parameter int FW    = 8,
    parameter int DW    = 4,
    parameter int IW    = 32,
    parameter int PCW   = 64,
    parameter int CW    = $clog2(DW + 1),
    parameter int OW    = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush_i,
    input  logic [FW-1:0]      fetch_vld_i,
    input  logic [FW*IW-1:0]   fetch_data_i,
    input  logic [PCW-1:0]     fetch_pc_i,
    output logic               fetch_rdy_o,
    output logic [DW-1:0]      dec_vld_o,
    output logic [DW*IW-1:0]   dec_data_o,
    output logic [DW*PCW-1:0]  dec_pc_o,
    input  logic [CW-1:0]      dec_take_i,
    output logic [OW-1:0]      count_o,
    output logic               empty_o,
    output logic               full_o
);

    localparam int AW  = $clog2(DEPTH);
    localparam int NW  = $clog2(FW + 1);
    localparam int OW1 = OW + 1;

    logic [AW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [OW-1:0]  count_q, count_d;
    logic [IW-1:0]  mem_q [DEPTH];
    logic [IW-1:0]  mem_d [DEPTH];
    logic [PCW-1:0] pcs_q [DEPTH];
    logic [PCW-1:0] pcs_d [DEPTH];

    logic [AW-1:0]  wr_idx [FW];
    logic [AW-1:0]  rd_idx [DW];
    logic [FW-1:0]  acc_mask;
    logic [NW-1:0]  run_len, n_enq;
    logic           run;
    logic           enq;
    logic [OW1-1:0] space;
    logic [CW-1:0]  avail, lim, n_vld, m_deq;

    for (genvar g = 0; g < FW; g++) begin : g_widx
        assign wr_idx[g] = tail_q + AW'(g);
    end
    for (genvar g = 0; g < DW; g++) begin : g_ridx
        assign rd_idx[g] = head_q + AW'(g);
    end

`ifdef CMOV_SPLIT_EN
    logic [DEPTH-1:0] cmov_q, cmov_d;
    logic             found;

    function automatic logic is_cmov(input logic [IW-1:0] ins);
        logic fn_hit;
        case (ins[11:5])
            7'h14, 7'h16, 7'h24, 7'h26,
            7'h44, 7'h46, 7'h64, 7'h66: fn_hit = 1'b1;
            default:                    fn_hit = 1'b0;
        endcase
        return (ins[31:26] == 6'h11) && fn_hit;
    endfunction

    // A head cmov issues alone; otherwise lanes stop just before the first cmov.
    always_comb begin
        lim   = CW'(DW);
        found = 1'b0;
        if (cmov_q[head_q]) begin
            lim = CW'(1);
        end else begin
            for (int k = 1; k < DW; k++) begin
                if (!found && cmov_q[rd_idx[k]]) begin
                    lim   = CW'(k);
                    found = 1'b1;
                end
            end
        end
    end
`else
    assign lim = CW'(DW);
`endif

    // Only the leading run of valid slots is accepted.
    always_comb begin
        run      = 1'b1;
        run_len  = '0;
        acc_mask = '0;
        for (int k = 0; k < FW; k++) begin
            if (run && fetch_vld_i[k]) begin
                run_len     = run_len + 1'b1;
                acc_mask[k] = 1'b1;
            end else begin
                run = 1'b0;
            end
        end
    end

    assign space       = OW1'(DEPTH) - {1'b0, count_q};
    assign fetch_rdy_o = (space >= OW1'(FW));
    assign enq         = fetch_rdy_o & fetch_vld_i[0];
    assign n_enq       = enq ? run_len : '0;

    assign avail = (count_q < OW'(DW)) ? CW'(count_q) : CW'(DW);
    assign n_vld = (avail < lim) ? avail : lim;
    assign m_deq = (dec_take_i > n_vld) ? n_vld : dec_take_i;

    always_comb begin
        dec_vld_o  = '0;
        dec_data_o = '0;
        dec_pc_o   = '0;
        for (int k = 0; k < DW; k++) begin
            if (CW'(k) < n_vld) begin
                dec_vld_o[k]            = 1'b1;
                dec_data_o[k*IW +: IW]  = mem_q[rd_idx[k]];
                dec_pc_o[k*PCW +: PCW]  = pcs_q[rd_idx[k]];
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        pcs_d   = pcs_q;
`ifdef CMOV_SPLIT_EN
        cmov_d  = cmov_q;
`endif
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            for (int k = 0; k < FW; k++) begin
                if (enq && acc_mask[k]) begin
                    mem_d[wr_idx[k]] = fetch_data_i[k*IW +: IW];
                    pcs_d[wr_idx[k]] = fetch_pc_i + PCW'(4 * k);
`ifdef CMOV_SPLIT_EN
                    cmov_d[wr_idx[k]] = is_cmov(fetch_data_i[k*IW +: IW]);
`endif
                end
            end
            tail_d  = tail_q + AW'(n_enq);
            head_d  = head_q + AW'(m_deq);
            count_d = count_q + OW'(n_enq) - OW'(m_deq);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

`ifdef CMOV_SPLIT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cmov_q <= '0;
        else          cmov_q <= cmov_d;
    end
`endif

    // Payload needs no reset: lanes are masked by count.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
        pcs_q <= pcs_d;
    end

    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == OW'(DEPTH));

endmodule

// File: tb/tb_inst_queue_mw.sv
// Directed, table-driven bench for inst_queue_mw with default parameters.
// Each table row is one clock of stimulus plus the state expected after it.
module tb_inst_queue_mw;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          flush_i;
    logic [7:0]    fetch_vld_i;
    logic [255:0]  fetch_data_i;
    logic [63:0]   fetch_pc_i;
    logic          fetch_rdy_o;
    logic [3:0]    dec_vld_o;
    logic [127:0]  dec_data_o;
    logic [255:0]  dec_pc_o;
    logic [2:0]    dec_take_i;
    logic [5:0]    count_o;
    logic          empty_o;
    logic          full_o;

    int n_cmp = 0;
    int n_bad = 0;

    inst_queue_mw dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .flush_i      (flush_i),
        .fetch_vld_i  (fetch_vld_i),
        .fetch_data_i (fetch_data_i),
        .fetch_pc_i   (fetch_pc_i),
        .fetch_rdy_o  (fetch_rdy_o),
        .dec_vld_o    (dec_vld_o),
        .dec_data_o   (dec_data_o),
        .dec_pc_o     (dec_pc_o),
        .dec_take_i   (dec_take_i),
        .count_o      (count_o),
        .empty_o      (empty_o),
        .full_o       (full_o)
    );

    always #5 clock = ~clock;

    // Slot k of a group with base b carries sequence number b+k:
    // data = 0x4000_0000 | seq, pc = 0x1000 + 4*seq.
    typedef struct {
        logic       fl;
        logic [7:0] vld;
        int         base;
        int         take;
        int         cnt;
        logic [3:0] dv;
        logic       rdy;
        int         head;
    } vec_t;

    vec_t tbl[29];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_raw(input logic fl, input logic [7:0] v, input logic [255:0] d,
                             input logic [63:0] pc, input int take);
        flush_i      = fl;
        fetch_vld_i  = v;
        fetch_data_i = d;
        fetch_pc_i   = pc;
        dec_take_i   = 3'(take);
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic fl, input logic [7:0] v, input int base, input int take);
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = 32'h4000_0000 | 32'(base + k);
        drive_raw(fl, v, d, 64'h1000 + 64'(4 * base), take);
    endtask

    task automatic chk_state(input string p, input int cnt, input logic [3:0] dv, input logic rdy);
        chk({p, " cnt"},   64'(count_o),     64'(cnt));
        chk({p, " vld"},   64'(dec_vld_o),   64'(dv));
        chk({p, " rdy"},   64'(fetch_rdy_o), 64'(rdy));
        chk({p, " empty"}, 64'(empty_o),     64'(cnt == 0));
        chk({p, " full"},  64'(full_o),      64'(cnt == 32));
    endtask

    initial begin
        logic [255:0] cd;
        logic [31:0]  ed;
        logic [63:0]  ep;

        reset_n      = 1'b0;
        flush_i      = 1'b0;
        fetch_vld_i  = '0;
        fetch_data_i = '0;
        fetch_pc_i   = '0;
        dec_take_i   = '0;

        tbl[0]  = '{1'b0, 8'hFF,   0, 0,  8, 4'hF, 1'b1,   0};
        tbl[1]  = '{1'b1, 8'hFF,  50, 4,  0, 4'h0, 1'b1,   0};
        tbl[2]  = '{1'b0, 8'hB7,   0, 0,  3, 4'h7, 1'b1,   0};
        tbl[3]  = '{1'b0, 8'hFF,   3, 0, 11, 4'hF, 1'b1,   0};
        tbl[4]  = '{1'b0, 8'hFF,  11, 0, 19, 4'hF, 1'b1,   0};
        tbl[5]  = '{1'b0, 8'h3F,  19, 0, 25, 4'hF, 1'b0,   0};
        tbl[6]  = '{1'b0, 8'hFF, 100, 1, 24, 4'hF, 1'b1,   1};
        tbl[7]  = '{1'b0, 8'hFF,  25, 0, 32, 4'hF, 1'b0,   1};
        tbl[8]  = '{1'b0, 8'h00,   0, 4, 28, 4'hF, 1'b0,   5};
        tbl[9]  = '{1'b0, 8'h00,   0, 4, 24, 4'hF, 1'b1,   9};
        tbl[10] = '{1'b0, 8'h00,   0, 4, 20, 4'hF, 1'b1,  13};
        tbl[11] = '{1'b0, 8'h00,   0, 4, 16, 4'hF, 1'b1,  17};
        tbl[12] = '{1'b0, 8'h00,   0, 4, 12, 4'hF, 1'b1,  21};
        tbl[13] = '{1'b0, 8'h00,   0, 4,  8, 4'hF, 1'b1,  25};
        tbl[14] = '{1'b0, 8'h00,   0, 4,  4, 4'hF, 1'b1,  29};
        tbl[15] = '{1'b0, 8'h00,   0, 4,  0, 4'h0, 1'b1,   0};
        tbl[16] = '{1'b0, 8'hFF,  40, 0,  8, 4'hF, 1'b1,  40};
        tbl[17] = '{1'b0, 8'h03,  48, 0, 10, 4'hF, 1'b1,  40};
        tbl[18] = '{1'b0, 8'hFF,  50, 4, 14, 4'hF, 1'b1,  44};
        tbl[19] = '{1'b0, 8'h00,   0, 4, 10, 4'hF, 1'b1,  48};
        tbl[20] = '{1'b0, 8'h00,   0, 4,  6, 4'hF, 1'b1,  52};
        tbl[21] = '{1'b0, 8'h00,   0, 4,  2, 4'h3, 1'b1,  56};
        tbl[22] = '{1'b0, 8'h00,   0, 4,  0, 4'h0, 1'b1,   0};
        tbl[23] = '{1'b0, 8'hFF,  60, 0,  8, 4'hF, 1'b1,  60};
        tbl[24] = '{1'b0, 8'hFF,  68, 0, 16, 4'hF, 1'b1,  60};
        tbl[25] = '{1'b0, 8'h0F,  76, 0, 20, 4'hF, 1'b1,  60};
        tbl[26] = '{1'b1, 8'hFF,  90, 3,  0, 4'h0, 1'b1,   0};
        tbl[27] = '{1'b0, 8'hFF, 200, 0,  8, 4'hF, 1'b1, 200};
        tbl[28] = '{1'b0, 8'hFE, 300, 0,  8, 4'hF, 1'b1, 200};

        #12;
        chk_state("reset", 0, 4'h0, 1'b1);
        chk("reset data", dec_data_o[63:0], 64'h0);
        chk("reset pc",   dec_pc_o[63:0],   64'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 29; i++) begin
            drive(tbl[i].fl, tbl[i].vld, tbl[i].base, tbl[i].take);
            chk_state($sformatf("r%0d", i), tbl[i].cnt, tbl[i].dv, tbl[i].rdy);
            for (int k = 0; k < 4; k++) begin
                ed = tbl[i].dv[k] ? (32'h4000_0000 | 32'(tbl[i].head + k)) : 32'h0;
                ep = tbl[i].dv[k] ? (64'h1000 + 64'(4 * (tbl[i].head + k))) : 64'h0;
                chk($sformatf("r%0d data%0d", i, k), 64'(dec_data_o[k*32 +: 32]), 64'(ed));
                chk($sformatf("r%0d pc%0d", i, k),   dec_pc_o[k*64 +: 64],        ep);
            end
        end

        // CMOV split: ADDQ, ADDQ, CMOVEQ, ADDQ
        drive(1'b1, 8'h00, 0, 0);
        cd = '0;
        cd[31:0]   = 32'h4002_0402;
        cd[63:32]  = 32'h4002_0402;
        cd[95:64]  = 32'h4400_0480;
        cd[127:96] = 32'h4002_0402;
        drive_raw(1'b0, 8'h0F, cd, 64'h8000, 0);
`ifdef CMOV_SPLIT_EN
        chk_state("cmov0", 4, 4'h3, 1'b1);
        drive(1'b0, 8'h00, 0, 2);
        chk_state("cmov1", 2, 4'h1, 1'b1);
        chk("cmov1 data0", 64'(dec_data_o[31:0]), 64'h4400_0480);
        chk("cmov1 pc0",   dec_pc_o[63:0],        64'h8008);
        drive(1'b0, 8'h00, 0, 3);
        chk_state("cmov2", 1, 4'h1, 1'b1);
        chk("cmov2 data0", 64'(dec_data_o[31:0]), 64'h4002_0402);
`else
        chk_state("cmov0", 4, 4'hF, 1'b1);
        chk("cmov0 data2", 64'(dec_data_o[95:64]), 64'h4400_0480);
        chk("cmov0 pc3",   dec_pc_o[255:192],      64'h800C);
`endif

        // Asynchronous reset mid-cycle clears state without a clock edge.
        drive(1'b0, 8'hFF, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_state("areset", 0, 4'h0, 1'b1);
        chk("areset data", dec_data_o[63:0], 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
